// File: rtl/image_streamer_pkg.sv
// -----------------------------------------------------------------------------
// image_stream_pkg
// Shared types and helpers for the raster image streamer.
//   coord_t          : 16-bit unsigned pixel coordinate (col/row).
//   streamer_state_t : streamer sequencing states.
//   last_col/last_row: end-of-line / end-of-frame coordinate compares.
// -----------------------------------------------------------------------------
package image_stream_pkg;

  typedef logic [15:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ACTIVE,
    LBLANK,
    FBLANK
  } streamer_state_t;

  // Wrap is decided by compare against size-1, never by counter overflow.
  function automatic logic last_col(input coord_t col, input coord_t width);
    return col == (width - 16'd1);
  endfunction

  function automatic logic last_row(input coord_t row, input coord_t height);
    return row == (height - 16'd1);
  endfunction

endpackage

// File: rtl/image_streamer_blank_timer.sv
// -----------------------------------------------------------------------------
// blank_timer
// 16-bit down-counter used to time line and frame blanking intervals.
//   clk_i, rst_n_i : clock, asynchronous active-low reset.
//   load_i         : load load_val_i into the counter (starts the interval).
//   load_val_i     : interval length in cycles.
//   busy_o         : counter non-zero.
//   done_o         : final cycle of the interval (counter == 1).
// -----------------------------------------------------------------------------
module blank_timer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        busy_o,
  output logic        done_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 16'd0);
  assign done_o = (cnt_q == 16'd1);

endmodule

// File: rtl/image_streamer.sv
// -----------------------------------------------------------------------------
// image_streamer
// Raster pixel source: accepts beats from a ready/valid upstream carrying a
// start-of-frame marker and emits a coordinate-tagged push stream with one
// cycle of latency. Enforces frame sync and inserts line/frame blanking.
//   clk_i, rst_n_i : clock, asynchronous active-low reset.
//   start_i        : level enable; frames stream while high.
//   s_data_i       : upstream pixel.
//   s_sof_i        : upstream beat is the first pixel of a frame.
//   s_valid_i      : upstream beat valid.
//   s_ready_o      : beat accepted when s_valid_i && s_ready_o.
//   data_o         : pixel (held when valid_o=0).
//   col_o, row_o   : pixel coordinates (held when valid_o=0).
//   valid_o        : one-cycle pixel strobe.
//   frame_done_o   : pulses with valid_o of the last pixel of a frame.
//   sync_err_o     : sticky misplaced-sof flag, cleared only by reset.
// -----------------------------------------------------------------------------
module image_streamer
  import image_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int LINE_BLANK   = 0,
  parameter int FRAME_BLANK  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_sof_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           col_o,
  output logic [15:0]           row_o,
  output logic                  valid_o,
  output logic                  frame_done_o,
  output logic                  sync_err_o
);

  localparam coord_t IMG_W = coord_t'(IMAGE_WIDTH);
  localparam coord_t IMG_H = coord_t'(IMAGE_HEIGHT);
  localparam coord_t LB_LEN = coord_t'(LINE_BLANK);
  localparam coord_t FB_LEN = coord_t'(FRAME_BLANK);

  streamer_state_t       state_q;
  coord_t                col_cnt_q;
  coord_t                row_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  coord_t                col_q;
  coord_t                row_q;
  logic                  valid_q;
  logic                  frame_done_q;
  logic                  sync_err_q;

  logic   accept;
  logic   at_last_col;
  logic   at_last_row;
  logic   tmr_load;
  coord_t tmr_val;
  logic   tmr_busy;
  logic   tmr_done;
  logic   blank_end;

  // Ready depends on state only so upstream never sees a valid->ready path.
  assign s_ready_o   = (state_q == SYNC) || (state_q == ACTIVE);
  assign accept      = s_valid_i && s_ready_o;
  assign at_last_col = last_col(col_cnt_q, IMG_W);
  assign at_last_row = last_row(row_cnt_q, IMG_H);

  // The timer is armed on the accept that ends a line or frame, so the
  // blanking state sees the full count on its first cycle.
  assign tmr_load = (state_q == ACTIVE) && accept && !s_sof_i && at_last_col &&
                    ((at_last_row && (FRAME_BLANK > 0)) ||
                     (!at_last_row && (LINE_BLANK > 0)));
  assign tmr_val  = at_last_row ? FB_LEN : LB_LEN;

  // An idle timer also ends blanking so the FSM can never park in a blank state.
  assign blank_end = tmr_done || !tmr_busy;

  blank_timer u_blank_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .busy_o     (tmr_busy),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      data_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SYNC;
          end
        end

        SYNC: begin
          // Non-sof beats are consumed and dropped until the frame start.
          if (accept && s_sof_i) begin
            data_q    <= s_data_i;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b1;
            col_cnt_q <= 16'd1;
            row_cnt_q <= '0;
            state_q   <= ACTIVE;
          end else if (!start_i) begin
            state_q <= IDLE;
          end
        end

        ACTIVE: begin
          if (accept) begin
            data_q  <= s_data_i;
            valid_q <= 1'b1;
            if (s_sof_i) begin
              // Misplaced sof: resynchronise on this beat as a new frame.
              sync_err_q <= 1'b1;
              col_q      <= '0;
              row_q      <= '0;
              col_cnt_q  <= 16'd1;
              row_cnt_q  <= '0;
            end else begin
              col_q <= col_cnt_q;
              row_q <= row_cnt_q;
              if (at_last_col) begin
                col_cnt_q <= '0;
                if (at_last_row) begin
                  row_cnt_q    <= '0;
                  frame_done_q <= 1'b1;
                  if (FRAME_BLANK > 0) begin
                    state_q <= FBLANK;
                  end else if (start_i) begin
                    state_q <= SYNC;
                  end else begin
                    state_q <= IDLE;
                  end
                end else begin
                  row_cnt_q <= row_cnt_q + 16'd1;
                  if (LINE_BLANK > 0) begin
                    state_q <= LBLANK;
                  end
                end
              end else begin
                col_cnt_q <= col_cnt_q + 16'd1;
              end
            end
          end
        end

        LBLANK: begin
          if (blank_end) begin
            state_q <= ACTIVE;
          end
        end

        FBLANK: begin
          if (blank_end) begin
            state_q <= start_i ? SYNC : IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign valid_o      = valid_q;
  assign frame_done_o = frame_done_q;
  assign sync_err_o   = sync_err_q;

endmodule
